mem_bus_arbiter: RTL

Two-master bus controller between the pipeline and a single Wishbone-style memory port. It shares the port between instruction fetch (read-only) and the memory-stage data access (loads, stores, LL/SC). It sequences each access as a registered bus cycle, raises stall requests toward the pipeline controller, and holds returned data until the owning stage is released. It sits between the IF/MEM stages and the external bus.

---
 rtl/mem_bus_arbiter_pkg.sv | 28 ++
 rtl/mem_bus_arbiter_if.sv | 24 ++
 rtl/mem_bus_watchdog.sv | 39 +++
 rtl/mem_bus_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter:
// FSM state and owner encodings, stall-vector indices and the zero word.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_e;

  localparam int STALL_W   = 6;
  localparam int STALL_IF  = 1;
  localparam int STALL_MEM = 4;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Pipeline stall bit that belongs to the stage owning the bus.
  function automatic logic owner_stalled(input owner_e owner,
                                         input logic [STALL_W-1:0] stall);
    return (owner == DATA) ? stall[STALL_MEM] : stall[STALL_IF];
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Wishbone-style single-port memory bus. The arbiter drives it through the
// master modport; the memory (or a testbench slave) uses the slave modport.
interface mem_bus_arbiter_if;

  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/mem_bus_watchdog.sv
// Bus-cycle timeout counter: clears when a bus cycle starts and flags the
// TIMEOUT_CYCLES-th consecutive BUSY cycle that passes without an ack.
module mem_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic busy_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam int CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CntW-1:0] cnt_q, cnt_d;

  // The count holds the number of ack-less BUSY cycles already completed, so
  // the limit is hit while the last permitted cycle is still in progress.
  assign timeout_o = busy_i && !ack_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (busy_i && !ack_i && !timeout_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch / data) arbiter onto one Wishbone-style port with pipeline
// stall requests and held read data. Define MEM_BUS_TIMEOUT_EN for the watchdog.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               if_ce_i,
  input  logic [31:0]        if_addr_i,
  output logic [31:0]        if_rdata_o,
  output logic               if_stallreq_o,
  input  logic               d_ce_i,
  input  logic               d_we_i,
  input  logic [31:0]        d_addr_i,
  input  logic [3:0]         d_sel_i,
  input  logic [31:0]        d_wdata_i,
  output logic [31:0]        d_rdata_o,
  output logic               d_stallreq_o,
  output logic               bus_err_o,
  mem_bus_arbiter_if.master  wb
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [31:0] wb_adr_q, wb_adr_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic [3:0]  wb_sel_q, wb_sel_d;
  logic        wb_we_q, wb_we_d;
  logic        wb_cyc_q, wb_cyc_d;
  logic        wb_stb_q, wb_stb_d;
  logic [31:0] if_hold_q, if_hold_d;
  logic [31:0] d_hold_q, d_hold_d;

  logic        start_busy;
  logic        timeout;
  logic        done;
  logic        owner_ce;
  logic        owner_stall;
  logic [31:0] cap_word;

  // Only the IF and MEM stall bits steer this block.
  logic unused_stall;
  assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

  assign owner_ce    = (owner_q == DATA) ? d_ce_i : if_ce_i;
  assign owner_stall = owner_stalled(owner_q, stall_i);
  // A timeout finishes the access like an ack, but returns the zero word.
  assign done        = (state_q == BUSY) && !flush_i && (wb.wb_ack_i || timeout);
  assign cap_word    = wb.wb_ack_i ? wb.wb_dat_i : ZeroWord;

  // NOTE: every signal written below gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wb_adr_d   = wb_adr_q;
    wb_dat_d   = wb_dat_q;
    wb_sel_d   = wb_sel_q;
    wb_we_d    = wb_we_q;
    wb_cyc_d   = wb_cyc_q;
    wb_stb_d   = wb_stb_q;
    if_hold_d  = if_hold_q;
    d_hold_d   = d_hold_q;
    start_busy = 1'b0;

    if_rdata_o    = if_hold_q;
    d_rdata_o     = d_hold_q;
    if_stallreq_o = if_ce_i;
    d_stallreq_o  = d_ce_i;

    unique case (state_q)
      IDLE: begin
        if (!flush_i && (d_ce_i || if_ce_i)) begin
          start_busy = 1'b1;
          state_d    = BUSY;
          wb_cyc_d   = 1'b1;
          wb_stb_d   = 1'b1;
          if (d_ce_i) begin
            owner_d  = DATA;
            wb_adr_d = d_addr_i;
            wb_we_d  = d_we_i;
            wb_sel_d = d_sel_i;
            wb_dat_d = d_wdata_i;
          end else begin
            owner_d  = FETCH;
            wb_adr_d = if_addr_i;
            wb_we_d  = 1'b0;
            wb_sel_d = 4'b1111;
            wb_dat_d = ZeroWord;
          end
        end
      end

      BUSY: begin
        if (owner_q == DATA) begin
          d_stallreq_o = !done;
          if (done) d_rdata_o = cap_word;
        end else begin
          if_stallreq_o = !done;
          if (done) if_rdata_o = cap_word;
        end

        if (flush_i) begin
          // The flushed access is abandoned; an ack in this cycle is dropped.
          state_d  = IDLE;
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
          wb_we_d  = 1'b0;
        end else if (done) begin
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
          wb_we_d  = 1'b0;
          if (owner_q == DATA) d_hold_d  = cap_word;
          else                 if_hold_d = cap_word;
          state_d = (owner_stall && owner_ce) ? HOLD : IDLE;
        end
      end

      HOLD: begin
        if (owner_q == DATA) d_stallreq_o  = 1'b0;
        else                 if_stallreq_o = 1'b0;
        if (flush_i || !owner_stall) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      if_stallreq_o = 1'b0;
      d_stallreq_o  = 1'b0;
    end
  end

`ifdef MEM_BUS_TIMEOUT_EN
  mem_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_busy),
    .busy_i    (state_q == BUSY),
    .ack_i     (wb.wb_ack_i),
    .timeout_o (timeout)
  );
  assign bus_err_o = timeout && !flush_i;
`else
  logic unused_start;
  assign unused_start = start_busy;
  assign timeout      = 1'b0;
  assign bus_err_o    = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values of the previous cycle, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= FETCH;
      wb_adr_q  <= ZeroWord;
      wb_dat_q  <= ZeroWord;
      wb_sel_q  <= 4'b0000;
      wb_we_q   <= 1'b0;
      wb_cyc_q  <= 1'b0;
      wb_stb_q  <= 1'b0;
      if_hold_q <= ZeroWord;
      d_hold_q  <= ZeroWord;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wb_adr_q  <= wb_adr_d;
      wb_dat_q  <= wb_dat_d;
      wb_sel_q  <= wb_sel_d;
      wb_we_q   <= wb_we_d;
      wb_cyc_q  <= wb_cyc_d;
      wb_stb_q  <= wb_stb_d;
      if_hold_q <= if_hold_d;
      d_hold_q  <= d_hold_d;
    end
  end

  assign wb.wb_adr_o = wb_adr_q;
  assign wb.wb_dat_o = wb_dat_q;
  assign wb.wb_sel_o = wb_sel_q;
  assign wb.wb_we_o  = wb_we_q;
  assign wb.wb_cyc_o = wb_cyc_q;
  assign wb.wb_stb_o = wb_stb_q;

endmodule
